// File: rtl/cfg_bank_pkg.sv
// Shared definitions for the memory-bank (BL/WL) configuration writer.
// Holds the FSM state encoding, default geometry constants and the
// beats-per-frame helper used by the writer and the frame packer.
package cfg_bank_pkg;

  localparam int unsigned DEF_BL_W     = 72;
  localparam int unsigned DEF_WL_W     = 72;
  localparam int unsigned DEF_DATA_W   = 8;
  localparam int unsigned DEF_WL_PULSE = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_DONE
  } state_e;

  // Number of stream beats that make up one bit-line frame.
  function automatic int unsigned beats_per_frame(input int unsigned bl_w,
                                                  input int unsigned data_w);
    return bl_w / data_w;
  endfunction

endpackage

// File: rtl/cfg_frame_packer.sv
// Packs DATA_W-bit stream beats into one BL_W-bit frame.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   clear         restart packing at beat 0 (start of a pass)
//   beat_en       a beat is accepted this cycle
//   s_data        beat payload; bit i lands in frame bit k*DATA_W+i
//   frame_full_c  the accepted beat completes the frame (combinational)
//   frame_c       packed frame including the beat accepted this cycle
module cfg_frame_packer
  import cfg_bank_pkg::*;
#(
  parameter int unsigned BL_W   = DEF_BL_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              beat_en,
  input  logic [0:DATA_W-1] s_data,
  output logic              frame_full_c,
  output logic [0:BL_W-1]   frame_c
);

  localparam int unsigned BEATS = beats_per_frame(BL_W, DATA_W);
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [0:BL_W-1]  pack_q, pack_d;

  // Beat counter and packing buffer next-state.
  always_comb begin
    beat_cnt_d   = beat_cnt_q;
    pack_d       = pack_q;
    frame_full_c = 1'b0;
    if (clear) begin
      beat_cnt_d = '0;
    end else if (beat_en) begin
      for (int unsigned k = 0; k < BEATS; k++) begin
        if (beat_cnt_q == CNT_W'(k)) begin
          pack_d[k*DATA_W +: DATA_W] = s_data;
        end
      end
      if (beat_cnt_q == CNT_W'(BEATS - 1)) begin
        beat_cnt_d   = '0;
        frame_full_c = 1'b1;
      end else begin
        beat_cnt_d = beat_cnt_q + CNT_W'(1);
      end
    end
  end

  // The writer copies the frame on the same edge as the last beat,
  // so the frame view includes the beat being accepted now.
  assign frame_c = pack_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_q <= '0;
      pack_q     <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      pack_q     <= pack_d;
    end
  end

endmodule

// File: rtl/cfg_bank_writer.sv
// Memory-bank configuration writer: packs streamed config beats into
// BL_W-bit frames and programs one frame per row by driving the bit lines
// and pulsing a single word line, walking rows 0..WL_W-1 once per start.
// Ports:
//   prog_clk, prog_rst_n  clock, asynchronous active-low reset
//   start                 begin a programming pass (only honoured in IDLE)
//   s_data/s_valid/s_ready config beat stream
//   bl                    bit-line bus (held stable around each wl pulse)
//   wl                    word-line bus, at most one bit high
//   row                   row currently being programmed
//   busy                  pass in progress
//   done                  one-cycle pulse when the last row is finished
module cfg_bank_writer
  import cfg_bank_pkg::*;
#(
  parameter  int unsigned BL_W     = DEF_BL_W,
  parameter  int unsigned WL_W     = DEF_WL_W,
  parameter  int unsigned DATA_W   = DEF_DATA_W,
  parameter  int unsigned WL_PULSE = DEF_WL_PULSE,
  localparam int unsigned ROW_W    = (WL_W > 1) ? $clog2(WL_W) : 1
) (
  input  logic              prog_clk,
  input  logic              prog_rst_n,
  input  logic              start,
  input  logic [0:DATA_W-1] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [0:BL_W-1]   bl,
  output logic [0:WL_W-1]   wl,
  output logic [ROW_W-1:0]  row,
  output logic              busy,
  output logic              done
);

  localparam int unsigned PULSE_W = (WL_PULSE > 1) ? $clog2(WL_PULSE) : 1;

  if (((BL_W % DATA_W) != 0) || (WL_PULSE < 1)) begin : g_param_check
    $error("cfg_bank_writer: BL_W must be a multiple of DATA_W and WL_PULSE must be >= 1");
  end

  state_e             state_q, state_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [PULSE_W-1:0] pulse_cnt_q, pulse_cnt_d;
  logic [0:BL_W-1]    bl_q, bl_d;
  logic [0:WL_W-1]    wl_q, wl_d;
  logic               s_ready_q, s_ready_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               pack_clear_c;
  logic               beat_en_c;
  logic               frame_full_c;
  logic [0:BL_W-1]    frame_c;

  // s_ready_q is high exactly while in LOAD, so it qualifies acceptance.
  assign beat_en_c = s_valid && s_ready_q;

  cfg_frame_packer #(
    .BL_W   (BL_W),
    .DATA_W (DATA_W)
  ) u_packer (
    .clk          (prog_clk),
    .rst_n        (prog_rst_n),
    .clear        (pack_clear_c),
    .beat_en      (beat_en_c),
    .s_data       (s_data),
    .frame_full_c (frame_full_c),
    .frame_c      (frame_c)
  );

  // Next-state, counters and registered outputs derived from next state.
  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    pulse_cnt_d  = pulse_cnt_q;
    bl_d         = bl_q;
    pack_clear_c = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d      = ST_LOAD;
          row_d        = '0;
          pack_clear_c = 1'b1;
        end
      end
      ST_LOAD: begin
        if (frame_full_c) begin
          bl_d    = frame_c;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        state_d     = ST_PULSE;
        pulse_cnt_d = '0;
      end
      ST_PULSE: begin
        if (pulse_cnt_q == PULSE_W'(WL_PULSE - 1)) begin
          state_d = ST_HOLD;
        end else begin
          pulse_cnt_d = pulse_cnt_q + PULSE_W'(1);
        end
      end
      ST_HOLD: begin
        if (row_q == ROW_W'(WL_W - 1)) begin
          state_d = ST_DONE;
        end else begin
          row_d   = row_q + ROW_W'(1);
          state_d = ST_LOAD;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    s_ready_d = (state_d == ST_LOAD);
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_d == ST_DONE);
    for (int unsigned r = 0; r < WL_W; r++) begin
      wl_d[r] = (state_d == ST_PULSE) && (row_d == ROW_W'(r));
    end
  end

  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      state_q     <= ST_IDLE;
      row_q       <= '0;
      pulse_cnt_q <= '0;
      bl_q        <= '0;
      wl_q        <= '0;
      s_ready_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      pulse_cnt_q <= pulse_cnt_d;
      bl_q        <= bl_d;
      wl_q        <= wl_d;
      s_ready_q   <= s_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign s_ready = s_ready_q;
  assign bl      = bl_q;
  assign wl      = wl_q;
  assign row     = row_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_cfg_bank_writer.sv
// Bench for cfg_bank_writer with BL_W=72, DATA_W=8, WL_W=4, WL_PULSE=2.
// Expected behaviour per cycle is planned from a per-cycle valid pattern
// and the beat list before each pass.
module tb_cfg_bank_writer;

  localparam int unsigned BL_W     = 72;
  localparam int unsigned WL_W     = 4;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned WL_PULSE = 2;
  localparam int unsigned ROW_W    = 2;
  localparam int unsigned BEATS    = BL_W / DATA_W;
  localparam int unsigned NBEAT    = BEATS * WL_W;
  localparam int          MAXC     = 512;

  logic              prog_clk;
  logic              prog_rst_n;
  logic              start;
  logic [0:DATA_W-1] s_data;
  logic              s_valid;
  logic              s_ready;
  logic [0:BL_W-1]   bl;
  logic [0:WL_W-1]   wl;
  logic [ROW_W-1:0]  row;
  logic              busy;
  logic              done;

  cfg_bank_writer #(
    .BL_W     (BL_W),
    .WL_W     (WL_W),
    .DATA_W   (DATA_W),
    .WL_PULSE (WL_PULSE)
  ) dut (
    .prog_clk   (prog_clk),
    .prog_rst_n (prog_rst_n),
    .start      (start),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .bl         (bl),
    .wl         (wl),
    .row        (row),
    .busy       (busy),
    .done       (done)
  );

  initial prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  int n_cmp = 0;
  int n_err = 0;

  // Stimulus plan and expected per-cycle outputs (cycle 1 = first after start).
  logic [0:DATA_W-1] data_pat  [NBEAT];
  bit                valid_pat [MAXC];
  bit                start_pat [MAXC];
  int                drive_idx [MAXC];
  bit                exp_ready [MAXC];
  logic [0:WL_W-1]   exp_wl    [MAXC];
  logic [0:BL_W-1]   exp_bl    [MAXC];
  int                exp_row   [MAXC];
  bit                exp_busy  [MAXC];
  bit                exp_done  [MAXC];
  int                pulse_first [WL_W];
  logic [0:BL_W-1]   bl_model;
  int                done_at;
  int                obs_done_at;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic set_exp(input int c, input bit rdy, input logic [0:WL_W-1] w,
                         input logic [0:BL_W-1] b, input int r, input bit bsy, input bit dn);
    exp_ready[c] = rdy;
    exp_wl[c]    = w;
    exp_bl[c]    = b;
    exp_row[c]   = r;
    exp_busy[c]  = bsy;
    exp_done[c]  = dn;
  endtask

  // Plan one pass: LOAD lasts until BEATS valid cycles, then SETUP, WL_PULSE
  // pulse cycles, HOLD; DONE after the last row, then IDLE.
  task automatic plan_pass();
    int c = 1;
    int k = 0;
    logic [0:BL_W-1] frame;
    logic [0:WL_W-1] onehot;
    for (int r = 0; r < int'(WL_W); r++) begin
      int nb = 0;
      frame = '0;
      while (nb < int'(BEATS)) begin
        if (c > MAXC - 20) begin
          $display("FAIL plan: pass does not fit in %0d cycles", MAXC);
          $fatal(1);
        end
        set_exp(c, 1'b1, '0, bl_model, r, 1'b1, 1'b0);
        drive_idx[c] = k;
        if (valid_pat[c]) begin
          frame[nb*DATA_W +: DATA_W] = data_pat[k];
          k++;
          nb++;
        end
        c++;
      end
      bl_model = frame;
      set_exp(c, 1'b0, '0, bl_model, r, 1'b1, 1'b0);
      c++;
      onehot = '0;
      onehot[r] = 1'b1;
      pulse_first[r] = c;
      for (int p = 0; p < int'(WL_PULSE); p++) begin
        set_exp(c, 1'b0, onehot, bl_model, r, 1'b1, 1'b0);
        c++;
      end
      set_exp(c, 1'b0, '0, bl_model, r, 1'b1, 1'b0);
      c++;
    end
    set_exp(c, 1'b0, '0, bl_model, int'(WL_W) - 1, 1'b1, 1'b1);
    done_at = c;
    set_exp(c + 1, 1'b0, '0, bl_model, int'(WL_W) - 1, 1'b0, 1'b0);
  endtask

  // Drive a planned pass and compare every cycle; abort_at > 0 applies reset
  // at that cycle and checks the immediate clear.
  task automatic run_pass(input int abort_at);
    obs_done_at = -1;
    @(negedge prog_clk);
    chk("idle_ready_at_start", {127'd0, s_ready}, 128'd0);
    start   = 1'b1;
    s_valid = 1'b1;
    s_data  = DATA_W'($urandom);
    for (int c = 1; c <= done_at + 1; c++) begin
      @(negedge prog_clk);
      chk($sformatf("s_ready c%0d", c), {127'd0, s_ready}, {127'd0, exp_ready[c]});
      chk($sformatf("wl c%0d", c),      {124'd0, wl},      {124'd0, exp_wl[c]});
      chk($sformatf("bl c%0d", c),      {56'd0, bl},       {56'd0, exp_bl[c]});
      chk($sformatf("row c%0d", c),     {126'd0, row},     128'(exp_row[c]));
      chk($sformatf("busy c%0d", c),    {127'd0, busy},    {127'd0, exp_busy[c]});
      chk($sformatf("done c%0d", c),    {127'd0, done},    {127'd0, exp_done[c]});
      if (done === 1'b1 && obs_done_at < 0) obs_done_at = c;
      if (c == abort_at) begin
        prog_rst_n = 1'b0;
        #1;
        chk("rst_wl",    {124'd0, wl},      128'd0);
        chk("rst_bl",    {56'd0, bl},       128'd0);
        chk("rst_row",   {126'd0, row},     128'd0);
        chk("rst_busy",  {127'd0, busy},    128'd0);
        chk("rst_ready", {127'd0, s_ready}, 128'd0);
        start   = 1'b0;
        s_valid = 1'b0;
        @(negedge prog_clk);
        prog_rst_n = 1'b1;
        bl_model = '0;
        return;
      end
      start   = start_pat[c];
      s_valid = valid_pat[c];
      if (exp_ready[c] && valid_pat[c]) s_data = data_pat[drive_idx[c]];
      else                              s_data = DATA_W'($urandom);
    end
    start   = 1'b0;
    s_valid = 1'b0;
  endtask

  task automatic clear_pats();
    for (int c = 0; c < MAXC; c++) begin
      valid_pat[c] = 1'b1;
      start_pat[c] = 1'b0;
    end
  endtask

  task automatic seq_data();
    for (int k = 0; k < int'(NBEAT); k++) data_pat[k] = DATA_W'(k + 1);
  endtask

  task automatic rand_pass_setup();
    clear_pats();
    for (int k = 0; k < int'(NBEAT); k++) data_pat[k] = DATA_W'($urandom);
    for (int c = 0; c < MAXC; c++) valid_pat[c] = ($urandom_range(0, 9) < 7);
  endtask

  // Invariants: one-hot wl, no s_ready during a pulse, bl frozen around pulses.
  logic [0:WL_W-1] mon_wl_prev;
  logic [0:BL_W-1] mon_bl_prev;
  initial begin
    mon_wl_prev = '0;
    mon_bl_prev = '0;
  end
  always @(negedge prog_clk) begin
    if (!prog_rst_n) begin
      mon_wl_prev = '0;
      mon_bl_prev = bl;
    end else begin
      chk("mon_wl_onehot", 128'($countones(wl) <= 1), 128'd1);
      if (|wl) chk("mon_ready_in_pulse", {127'd0, s_ready}, 128'd0);
      if ((|wl) || (|mon_wl_prev)) chk("mon_bl_stable", {56'd0, bl}, {56'd0, mon_bl_prev});
      mon_wl_prev = wl;
      mon_bl_prev = bl;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    logic [0:BL_W-1] last_frame;
    last_frame = 72'h1C1D1E1F2021222324;

    // Reset and idle: nothing happens, s_valid is never accepted.
    prog_rst_n = 1'b0;
    start      = 1'b0;
    s_valid    = 1'b1;
    s_data     = 8'hA5;
    bl_model   = '0;
    repeat (3) @(negedge prog_clk);
    chk("in_rst_ready", {127'd0, s_ready}, 128'd0);
    chk("in_rst_bl",    {56'd0, bl},       128'd0);
    chk("in_rst_wl",    {124'd0, wl},      128'd0);
    prog_rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge prog_clk);
      s_data = DATA_W'($urandom);
      chk("idle_ready", {127'd0, s_ready}, 128'd0);
      chk("idle_busy",  {127'd0, busy},    128'd0);
      chk("idle_done",  {127'd0, done},    128'd0);
      chk("idle_wl",    {124'd0, wl},      128'd0);
      chk("idle_bl",    {56'd0, bl},       128'd0);
      chk("idle_row",   {126'd0, row},     128'd0);
    end
    s_valid = 1'b0;

    // Continuous pass with beats 0x01..0x24.
    clear_pats();
    seq_data();
    plan_pass();
    run_pass(0);
    chk("cont_done_cycle", 128'(obs_done_at), 128'd53);
    chk("cont_last_bl", {56'd0, bl}, {56'd0, last_frame});

    // Same data with a 5-cycle stall inside the first frame.
    clear_pats();
    seq_data();
    for (int c = 5; c < 10; c++) valid_pat[c] = 1'b0;
    plan_pass();
    run_pass(0);
    chk("stall_done_cycle", 128'(obs_done_at), 128'd58);
    chk("stall_last_bl", {56'd0, bl}, {56'd0, last_frame});

    // start reissued during row 1 pulse and during DONE is ignored.
    clear_pats();
    seq_data();
    plan_pass();
    start_pat[pulse_first[1] - 1] = 1'b1;
    start_pat[pulse_first[1]]     = 1'b1;
    start_pat[done_at - 1]        = 1'b1;
    start_pat[done_at]            = 1'b1;
    run_pass(0);
    chk("restart_done_cycle", 128'(obs_done_at), 128'd53);

    // Random data and random valid.
    for (int n = 0; n < 2; n++) begin
      rand_pass_setup();
      plan_pass();
      run_pass(0);
    end

    // Reset during row 2 pulse, then a fresh pass from row 0.
    rand_pass_setup();
    plan_pass();
    run_pass(pulse_first[2]);
    chk("post_rst_bl",  {56'd0, bl},   128'd0);
    chk("post_rst_row", {126'd0, row}, 128'd0);
    rand_pass_setup();
    plan_pass();
    run_pass(0);

    repeat (2) @(negedge prog_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cfg_bank_writer.md
# cfg_bank_writer

Configuration-side driver for the memory-bank (BL/WL) programming interface used by the routing connection blocks and switch blocks. It accepts a configuration bitstream as a valid/ready stream of narrow beats and packs each group of beats into one BL_W-bit frame. It then programs that frame into the fabric by presenting it on the bit lines and pulsing exactly one word line, walking rows 0..WL_W-1 once per `start`. It sits in the fabric top-level programming path, between the bitstream loader and the bl/wl buses fanned out to the routing tiles.

## Interface
Parameters:
- BL_W, 72, bit-line width (frame size); must be a multiple of DATA_W
- WL_W, 72, number of word lines (rows per programming pass)
- DATA_W, 8, stream beat width
- WL_PULSE, 2, word-line high time in cycles, ≥1

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - prog_clk  in  1  programming clock; all state changes on rising edge
  - prog_rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to begin a full programming pass; ignored unless IDLE
- s_data  in  [0:DATA_W-1]  config beat
- s_valid  in  1  beat valid
- s_ready  out  1  beat accepted when s_valid && s_ready
- bl  out  [0:BL_W-1]  bit-line bus to fabric
- wl  out  [0:WL_W-1]  word-line bus to fabric; at most one bit high
- row  out  clog2(WL_W)  current row index
- busy  out  1  pass in progress
- done  out  1  one-cycle pulse at pass completion

## Operation
- States:
  - IDLE
  - LOAD: collect BL_W/DATA_W beats
  - SETUP: bl stable, wl low, 1 cycle
  - PULSE: wl[row] high, WL_PULSE cycles
  - HOLD: wl low, bl held, 1 cycle
  - DONE: 1 cycle
- IDLE→LOAD on start; row and beat counter cleared.
- LOAD: s_ready=1. Beat k (0-based within the frame) writes s_data[i] into packing-buffer bit k*DATA_W+i. After the last beat, the buffer is copied into the bl register on the same edge, and the state moves to SETUP.
- SETUP→PULSE unconditionally. PULSE counts WL_PULSE cycles, then HOLD.
- HOLD: if row==WL_W-1 go to DONE, else row++ and go to LOAD.
- DONE: done=1, then IDLE. bl keeps its last frame; wl stays all-zero.
- s_ready is 0 in every state except LOAD. Stalls (s_valid=0) in LOAD hold all state indefinitely.
- start while not IDLE is ignored, with no side effects.
- start and s_valid in the same IDLE cycle: the beat is not accepted (s_ready=0 in IDLE).
- Row counter never wraps within a pass. It resets to 0 only on the next start.
- Async reset mid-pass: immediately IDLE, wl=0, bl=0, row=0, counters cleared. Partially programmed rows are not retried.

## Timing
- Reset values: s_ready=0, bl=0, wl=0, row=0, busy=0, done=0.
- busy=1 from the cycle after start is sampled through the DONE cycle inclusive.
- Numbering cycles so that the last beat of a frame is accepted in cycle N:
  - cycle N+1 = SETUP, with new bl visible
  - cycles N+2..N+1+WL_PULSE: wl[row]=1
  - next cycle: HOLD
  - cycle after HOLD: s_ready=1 for the next row (or done=1 after the last row)
- bl never changes while any wl bit is high, nor in the cycle before or after a wl pulse.
- Minimum pass length with continuous valid: WL_W*(BL_W/DATA_W + WL_PULSE + 2) + 1 cycles after start.

## Structure
- Shared package cfg_bank_pkg holds:
  - state enum (IDLE, LOAD, SETUP, PULSE, HOLD, DONE)
  - default width constants
  - a function returning beats-per-frame (BL_W/DATA_W)
- One sub-module is natural: cfg_frame_packer. It contains the beat counter and packing buffer, and exposes frame_full plus the packed frame.
- The FSM, pulse counter and row counter stay in cfg_bank_writer.
- Elaboration-time check: BL_W % DATA_W == 0 and WL_PULSE ≥ 1.

## Test plan
Bench parameters: BL_W=72, DATA_W=8, WL_W=4, WL_PULSE=2.

- Reset/idle: hold prog_rst_n=0 then release, no start → all outputs 0 indefinitely; s_valid=1 is never accepted.
- Single pass, continuous beats 0x01..0x24 → four frames. Row 0: bl[0:7]=0x01 … bl[64:71]=0x09, and wl=1000 for exactly 2 cycles, 1 cycle after bl updates. Rows 1–3 follow with wl=0100, 0010, 0001. done pulses once, 4*(9+4)+1=53 cycles after start.
- Backpressure: drop s_valid for 5 cycles mid-frame → no wl activity until the 9th beat; bl content is unchanged versus the continuous run; pass is 5 cycles longer.
- start reissued during PULSE of row 1 → ignored; row sequence and done timing are identical to the single pass.
- Reset mid-pass: assert prog_rst_n=0 during row 2 PULSE → wl=0 and bl=0 in the same cycle. After release, a new start reprograms from row 0.
- Invariant monitor on all runs: popcount(wl)≤1; bl stable from SETUP through HOLD; s_ready only in LOAD.
